// File: rtl/wired_bus_arbiter.sv
// wired_bus_arbiter: round-robin owner arbiter for one resolved multi-driver net.
// Gives N_REQ requesters exclusive, time-shared ownership of a shared tri-state
// bus, with an all-released turnaround gap of TURN_CYC cycles between owners.
//
// Optional feature macro: WIRED_BUS_ARB_TIMEOUT_EN
//   defined   -> an owner is forcibly released after MAX_HOLD granted cycles
//   undefined -> ownership is unbounded and forced is tied low
//
// Ports:
//   clk     in   sole clock, rising edge
//   rst     in   asynchronous active-high reset
//   req     in   [N_REQ]          per-requester level request
//   gnt     out  [N_REQ]          registered one-hot grant, zero when no owner
//   gnt_id  out  [clog2(N_REQ)]   current owner index, holds last owner when idle
//   oe      out  [N_REQ]          driver enables for the shared net (== gnt)
//   busy    out                   high while in GRANT or TURN
//   forced  out                   one-cycle pulse when a grant is revoked by timeout
module wired_bus_arbiter #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned TURN_CYC = 1,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    output logic [N_REQ-1:0]           gnt,
    output logic [$clog2(N_REQ)-1:0]   gnt_id,
    output logic [N_REQ-1:0]           oe,
    output logic                       busy,
    output logic                       forced
);

    localparam int unsigned ID_W   = $clog2(N_REQ);
    localparam int unsigned TURN_W = 3;
    localparam int unsigned HOLD_W = 8;

    // Elaboration-time parameter range guard
    if (N_REQ < 2 || N_REQ > 16 || TURN_CYC < 1 || TURN_CYC > 7 ||
        MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_param
        $error("wired_bus_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t             state, state_d;
    logic [ID_W-1:0]    ptr, ptr_d;
    logic [TURN_W-1:0]  turn_cnt, turn_cnt_d;
    logic [N_REQ-1:0]   gnt_d;
    logic [ID_W-1:0]    gnt_id_d;
    logic               busy_d;

    logic               any_req_c;
    logic               win_found_c;
    logic [ID_W-1:0]    win_id_c;
    logic [ID_W:0]      idx_c;
    logic               take_c;

`ifdef WIRED_BUS_ARB_TIMEOUT_EN
    logic [HOLD_W-1:0]  hold_cnt, hold_cnt_d;
    logic               forced_d;
`endif

    // Round-robin search: first set request at or after ptr, wrapping
    always_comb begin
        any_req_c   = |req;
        win_found_c = 1'b0;
        win_id_c    = '0;
        idx_c       = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            idx_c = {1'b0, ptr} + (ID_W+1)'(i);
            if (idx_c >= (ID_W+1)'(N_REQ)) begin
                idx_c = idx_c - (ID_W+1)'(N_REQ);
            end
            if (!win_found_c && req[idx_c[ID_W-1:0]]) begin
                win_found_c = 1'b1;
                win_id_c    = idx_c[ID_W-1:0];
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state;
        ptr_d      = ptr;
        turn_cnt_d = turn_cnt;
        gnt_d      = gnt;
        gnt_id_d   = gnt_id;
        take_c     = 1'b0;
`ifdef WIRED_BUS_ARB_TIMEOUT_EN
        hold_cnt_d = hold_cnt;
        forced_d   = 1'b0;
`endif

        case (state)
            IDLE: begin
                take_c = any_req_c;
            end
            GRANT: begin
                if (!req[gnt_id]) begin
                    state_d    = TURN;
                    gnt_d      = '0;
                    turn_cnt_d = '0;
`ifdef WIRED_BUS_ARB_TIMEOUT_EN
                end else if (hold_cnt == HOLD_W'(MAX_HOLD - 1)) begin
                    // Owner used its full allowance: revoke regardless of req
                    state_d    = TURN;
                    gnt_d      = '0;
                    turn_cnt_d = '0;
                    forced_d   = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt + HOLD_W'(1);
`endif
                end
            end
            TURN: begin
                if (turn_cnt == TURN_W'(TURN_CYC - 1)) begin
                    if (any_req_c) begin
                        take_c = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    turn_cnt_d = turn_cnt + TURN_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase

        // New ownership: shared by IDLE and end-of-TURN arbitration
        if (take_c) begin
            state_d          = GRANT;
            gnt_d            = '0;
            gnt_d[win_id_c]  = 1'b1;
            gnt_id_d         = win_id_c;
            ptr_d            = (win_id_c == ID_W'(N_REQ - 1)) ? '0 : win_id_c + ID_W'(1);
`ifdef WIRED_BUS_ARB_TIMEOUT_EN
            hold_cnt_d       = '0;
`endif
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            turn_cnt <= '0;
            gnt      <= '0;
            oe       <= '0;
            gnt_id   <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_d;
            ptr      <= ptr_d;
            turn_cnt <= turn_cnt_d;
            gnt      <= gnt_d;
            oe       <= gnt_d;
            gnt_id   <= gnt_id_d;
            busy     <= busy_d;
        end
    end

`ifdef WIRED_BUS_ARB_TIMEOUT_EN
    // Hold-time counter and revoke pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
            forced   <= 1'b0;
        end else begin
            hold_cnt <= hold_cnt_d;
            forced   <= forced_d;
        end
    end
`else
    assign forced = 1'b0;
`endif

endmodule

// File: tb/tb_wired_bus_arbiter.sv
// Testbench for wired_bus_arbiter: two instances (TURN_CYC 1 and 3) share one
// request stream and are compared every cycle against an ownership-level model.
module tb_wired_bus_arbiter;

    localparam int N    = 4;
    localparam int MAXH = 8;
`ifdef WIRED_BUS_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;

    logic [3:0] gnt_a, oe_a, gnt_b, oe_b;
    logic [1:0] gnt_id_a, gnt_id_b;
    logic       busy_a, forced_a, busy_b, forced_b;

    always #5 clk = ~clk;

    wired_bus_arbiter #(.N_REQ(N), .TURN_CYC(1), .MAX_HOLD(MAXH)) dut_a (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt_a), .gnt_id(gnt_id_a),
        .oe(oe_a), .busy(busy_a), .forced(forced_a)
    );

    wired_bus_arbiter #(.N_REQ(N), .TURN_CYC(3), .MAX_HOLD(MAXH)) dut_b (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt_b), .gnt_id(gnt_id_b),
        .oe(oe_b), .busy(busy_b), .forced(forced_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Ownership model: owner (-1 = none), remaining gap cycles, pointer, hold count
    int m_owner [2];
    int m_last  [2];
    int m_ptr   [2];
    int m_gap   [2];
    int m_held  [2];
    bit m_forced[2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_owner[k]  = -1;
            m_last[k]   = 0;
            m_ptr[k]    = 0;
            m_gap[k]    = 0;
            m_held[k]   = 0;
            m_forced[k] = 1'b0;
        end
    endtask

    task automatic model_step(input int k, input logic [3:0] r);
        int tlen;
        int idx;
        tlen = (k == 0) ? 1 : 3;
        m_forced[k] = 1'b0;
        if (m_owner[k] >= 0) begin
            if (!r[m_owner[k]]) begin
                m_owner[k] = -1;
                m_gap[k]   = tlen;
            end else if (TO_EN && m_held[k] >= MAXH) begin
                m_owner[k]  = -1;
                m_gap[k]    = tlen;
                m_forced[k] = 1'b1;
            end else begin
                m_held[k]++;
            end
        end else if (m_gap[k] > 1) begin
            m_gap[k]--;
        end else begin
            m_gap[k] = 0;
            for (int i = 0; i < N; i++) begin
                idx = (m_ptr[k] + i) % N;
                if (m_owner[k] < 0 && r[idx]) begin
                    m_owner[k] = idx;
                    m_last[k]  = idx;
                    m_ptr[k]   = (idx + 1) % N;
                    m_held[k]  = 1;
                end
            end
        end
    endtask

    function automatic logic [3:0] exp_gnt(input int k);
        logic [3:0] g;
        g = 4'b0000;
        if (m_owner[k] >= 0) g[m_owner[k]] = 1'b1;
        return g;
    endfunction

    function automatic logic exp_busy(input int k);
        return (m_owner[k] >= 0) || (m_gap[k] > 0);
    endfunction

    task automatic compare_all();
        check("gnt_a",    32'(gnt_a),    32'(exp_gnt(0)));
        check("oe_a",     32'(oe_a),     32'(exp_gnt(0)));
        check("id_a",     32'(gnt_id_a), 32'(m_last[0]));
        check("busy_a",   32'(busy_a),   32'(exp_busy(0)));
        check("forced_a", 32'(forced_a), 32'(m_forced[0]));
        check("onehot_a", 32'($onehot0(gnt_a)), 32'd1);
        check("gnt_b",    32'(gnt_b),    32'(exp_gnt(1)));
        check("oe_b",     32'(oe_b),     32'(exp_gnt(1)));
        check("id_b",     32'(gnt_id_b), 32'(m_last[1]));
        check("busy_b",   32'(busy_b),   32'(exp_busy(1)));
        check("forced_b", 32'(forced_b), 32'(m_forced[1]));
        check("onehot_b", 32'($onehot0(gnt_b)), 32'd1);
    endtask

    // Drive req while clk is low, let the DUTs sample it, check at negedge
    task automatic cycle(input logic [3:0] r);
        req = r;
        @(posedge clk);
        model_step(0, r);
        model_step(1, r);
        @(negedge clk);
        compare_all();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_gnt_a"},  32'(gnt_a),    32'd0);
        check({tag, "_oe_a"},   32'(oe_a),     32'd0);
        check({tag, "_busy_a"}, 32'(busy_a),   32'd0);
        check({tag, "_id_a"},   32'(gnt_id_a), 32'd0);
        check({tag, "_frc_a"},  32'(forced_a), 32'd0);
        check({tag, "_gnt_b"},  32'(gnt_b),    32'd0);
        check({tag, "_busy_b"}, 32'(busy_b),   32'd0);
        check({tag, "_id_b"},   32'(gnt_id_b), 32'd0);
    endtask

    // Assert reset between clock edges and check outputs before any edge
    task automatic async_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("arst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] r;
        int         order[5];
        int         n_grants;
        logic [3:0] prev_gnt;
        int         cnt;
        int         run_len;
        bit         run_done;
        int         n_forced;

        order = '{0, 1, 2, 3, 0};
        model_reset();

        // Power-on reset
        @(negedge clk);
        @(negedge clk);
        check_reset_vals("por");
        rst = 1'b0;

        // Single-cycle request from IDLE: one grant cycle, TURN, back to IDLE
        cycle(4'b0010);
        check("pulse_gnt", 32'(gnt_a), 32'h2);
        for (int i = 0; i < 5; i++) cycle(4'b0000);
        check("pulse_idle", 32'(busy_b), 32'd0);

        // Async reset in the middle of a grant, then re-grant after release
        for (int i = 0; i < 3; i++) cycle(4'b0010);
        req = 4'b0010;
        async_reset();
        cycle(4'b0010);
        check("post_rst", 32'(gnt_a), 32'h2);

        // Round robin: all requesting, each owner releases after 2 cycles
        async_reset();
        n_grants = 0;
        prev_gnt = 4'b0000;
        for (int i = 0; i < 30; i++) begin
            r = 4'b1111;
            if (m_owner[0] >= 0 && m_held[0] >= 2) r[m_owner[0]] = 1'b0;
            cycle(r);
            if (gnt_a != 4'b0000 && prev_gnt == 4'b0000) begin
                if (n_grants < 5) check("rr_order", 32'(gnt_id_a), 32'(order[n_grants]));
                n_grants++;
            end
            prev_gnt = gnt_a;
        end
        check("rr_grants", 32'(n_grants >= 5), 32'd1);

        // Turnaround of 3 cycles on instance b: owner 2 releases, 0 pending
        async_reset();
        for (int i = 0; i < 3; i++) cycle(4'b0100);
        check("turn_owner", 32'(gnt_b), 32'h4);
        cycle(4'b0001);
        cnt = 0;
        while (gnt_b == 4'b0000 && busy_b && cnt < 10) begin
            cnt++;
            cycle(4'b0001);
        end
        check("turn_len", 32'(cnt), 32'd3);
        check("turn_next", 32'(gnt_b), 32'h1);

        // Constant single request: bounded by MAX_HOLD only with the timeout
        async_reset();
        run_len  = 0;
        run_done = 1'b0;
        n_forced = 0;
        for (int i = 0; i < 130; i++) begin
            cycle(4'b0001);
            if (forced_a) n_forced++;
            if (!run_done) begin
                if (gnt_a == 4'b0001) run_len++;
                else if (run_len > 0) run_done = 1'b1;
            end
        end
        check("hold_run", 32'(run_len), TO_EN ? 32'd8 : 32'd130);
        check("forced_cnt", 32'(n_forced), TO_EN ? 32'd14 : 32'd0);

        // Random traffic with occasional resets
        r = 4'b0000;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) async_reset();
            if ($urandom_range(0, 2) == 0) r = 4'($urandom);
            cycle(r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
